// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// opcode/funct constants, ALU operation codes, datapath select encodings
// and the packed control-output bundle driven by the FSM.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_SEL_AND = 4'h0;
    localparam logic [3:0] ALU_SEL_OR  = 4'h1;
    localparam logic [3:0] ALU_SEL_ADD = 4'h2;
    localparam logic [3:0] ALU_SEL_SUB = 4'h6;
    localparam logic [3:0] ALU_SEL_SLT = 4'h7;

    // Datapath select encodings
    localparam logic       ADDR_PC      = 1'b0;
    localparam logic       ADDR_ALU     = 1'b1;
    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_BR    = 2'd1;
    localparam logic [1:0] PC_SRC_JMP   = 2'd2;
    localparam logic       ALU_A_PC     = 1'b0;
    localparam logic       ALU_A_RS     = 1'b1;
    localparam logic [1:0] ALU_B_RT     = 2'd0;
    localparam logic [1:0] ALU_B_FOUR   = 2'd1;
    localparam logic [1:0] ALU_B_IMM    = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH = 2'd3;
    localparam logic       DST_RT       = 1'b0;
    localparam logic       DST_RD       = 1'b1;
    localparam logic       WB_FROM_ALU  = 1'b0;
    localparam logic       WB_FROM_MEM  = 1'b1;

    // All controller outputs, so reset gating is a single assignment.
    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       addr_sel;
        logic       ir_wr_ena;
        logic       pc_wr_ena;
        logic [1:0] pc_src_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [3:0] alu_sel;
        logic       w_reg_ena;
        logic       w_dst_sel;
        logic       wb_sel;
        logic       done;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps an R-type funct field to the ALU operation code and
// flags funct values the controller does not support.
//   func    : funct field of the current instruction
//   alu_sel : ALU operation code (ADD when funct is unsupported)
//   illegal : funct is not one of add/sub/and/or/slt
module multicycle_ctrl_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [3:0] alu_sel,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_SEL_ADD;
        illegal = 1'b0;
        case (func)
            FN_ADD:  alu_sel = ALU_SEL_ADD;
            FN_SUB:  alu_sel = ALU_SEL_SUB;
            FN_AND:  alu_sel = ALU_SEL_AND;
            FN_OR:   alu_sel = ALU_SEL_OR;
            FN_SLT:  alu_sel = ALU_SEL_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller. Sequences FETCH/DECODE/execute/memory/
// write-back states and drives the datapath selects, write enables and
// memory request. Memory requests time out after TIMEOUT_CYC cycles.
//   clk, rst_n        : clock, synchronous active-low reset
//   W_op, W_func      : opcode / funct from the instruction register
//   W_zero            : ALU zero flag (used in BRANCH)
//   W_mem_ack         : memory completes the pending request
//   R_mem_req/R_mem_wr/R_addr_sel : memory request controls
//   R_ir_wr_ena/R_pc_wr_ena/R_pc_src_sel : IR/PC loads
//   R_alu_a_sel/R_alu_b_sel/R_alu_sel    : ALU operand and operation selects
//   R_w_reg_ena/R_w_dst_sel/R_wb_sel     : register-file write-back
//   R_done/R_illegal/R_mem_err           : one-cycle status pulses
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] W_op,
    input  logic [5:0] W_func,
    input  logic       W_zero,
    input  logic       W_mem_ack,
    output logic       R_mem_req,
    output logic       R_mem_wr,
    output logic       R_addr_sel,
    output logic       R_ir_wr_ena,
    output logic       R_pc_wr_ena,
    output logic [1:0] R_pc_src_sel,
    output logic       R_alu_a_sel,
    output logic [1:0] R_alu_b_sel,
    output logic [3:0] R_alu_sel,
    output logic       R_w_reg_ena,
    output logic       R_w_dst_sel,
    output logic       R_wb_sel,
    output logic       R_done,
    output logic       R_illegal,
    output logic       R_mem_err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       r_type_q;   // remembers the R-type decision for WB_ALU
    logic       timeout;
    logic [3:0] fn_alu_sel;
    logic       fn_illegal;
    ctrl_t      c, c_out;

    multicycle_ctrl_alu_dec u_alu_dec (
        .func    (W_func),
        .alu_sel (fn_alu_sel),
        .illegal (fn_illegal)
    );

    // Ack in the timeout cycle wins, so timeout is qualified by !ack.
    assign timeout = c.mem_req && !W_mem_ack && (wait_cnt == WAIT_LAST);

    always_comb begin
        c         = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.addr_sel  = ADDR_PC;
                c.alu_a_sel = ALU_A_PC;
                c.alu_b_sel = ALU_B_FOUR;
                c.alu_sel   = ALU_SEL_ADD;
                if (W_mem_ack) begin
                    c.ir_wr_ena  = 1'b1;
                    c.pc_wr_ena  = 1'b1;
                    c.pc_src_sel = PC_SRC_PLUS4;
                    state_nxt    = S_DECODE;
                end
                // On timeout the state stays FETCH; the counter restarts.
            end
            S_DECODE: begin
                c.alu_a_sel = ALU_A_PC;
                c.alu_b_sel = ALU_B_IMM_SH;
                c.alu_sel   = ALU_SEL_ADD;
                state_nxt   = S_FETCH;
                case (W_op)
                    OP_RTYPE: begin
                        if (fn_illegal) c.illegal = 1'b1;
                        else            state_nxt = S_EXEC_R;
                    end
                    OP_ADDI:      state_nxt = S_EXEC_I;
                    OP_LW, OP_SW: state_nxt = S_ADDR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    default:      c.illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                c.alu_a_sel = ALU_A_RS;
                c.alu_b_sel = ALU_B_RT;
                c.alu_sel   = fn_alu_sel;
                state_nxt   = S_WB_ALU;
            end
            S_EXEC_I: begin
                c.alu_a_sel = ALU_A_RS;
                c.alu_b_sel = ALU_B_IMM;
                c.alu_sel   = ALU_SEL_ADD;
                state_nxt   = S_WB_ALU;
            end
            S_WB_ALU: begin
                c.w_reg_ena = 1'b1;
                c.wb_sel    = WB_FROM_ALU;
                c.w_dst_sel = r_type_q ? DST_RD : DST_RT;
                c.done      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_ADDR: begin
                c.alu_a_sel = ALU_A_RS;
                c.alu_b_sel = ALU_B_IMM;
                c.alu_sel   = ALU_SEL_ADD;
                state_nxt   = (W_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                c.mem_req  = 1'b1;
                c.addr_sel = ADDR_ALU;
                if (W_mem_ack)    state_nxt = S_WB_MEM;
                else if (timeout) state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                c.mem_req  = 1'b1;
                c.mem_wr   = 1'b1;
                c.addr_sel = ADDR_ALU;
                if (W_mem_ack) begin
                    c.done    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_FETCH;
                end
            end
            S_WB_MEM: begin
                c.w_reg_ena = 1'b1;
                c.wb_sel    = WB_FROM_MEM;
                c.w_dst_sel = DST_RT;
                c.done      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_a_sel  = ALU_A_RS;
                c.alu_b_sel  = ALU_B_RT;
                c.alu_sel    = ALU_SEL_SUB;
                c.pc_wr_ena  = W_zero;
                c.pc_src_sel = PC_SRC_BR;
                c.done       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_JUMP: begin
                c.pc_wr_ena  = 1'b1;
                c.pc_src_sel = PC_SRC_JMP;
                c.done       = 1'b1;
                state_nxt    = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        c.mem_err = timeout;
    end

    // The wait counter only runs while a request is outstanding; any ack,
    // timeout or non-request state leaves it at zero, which also gives the
    // clear-on-entry behaviour for FETCH/MEM_RD/MEM_WR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            r_type_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (c.mem_req && !W_mem_ack && !timeout) ? wait_cnt + 8'd1 : '0;
            if (state == S_DECODE)
                r_type_q <= (W_op == OP_RTYPE);
        end
    end

    // Every output, including the memory request, is held low during reset.
    assign c_out = rst_n ? c : '0;

    assign R_mem_req    = c_out.mem_req;
    assign R_mem_wr     = c_out.mem_wr;
    assign R_addr_sel   = c_out.addr_sel;
    assign R_ir_wr_ena  = c_out.ir_wr_ena;
    assign R_pc_wr_ena  = c_out.pc_wr_ena;
    assign R_pc_src_sel = c_out.pc_src_sel;
    assign R_alu_a_sel  = c_out.alu_a_sel;
    assign R_alu_b_sel  = c_out.alu_b_sel;
    assign R_alu_sel    = c_out.alu_sel;
    assign R_w_reg_ena  = c_out.w_reg_ena;
    assign R_w_dst_sel  = c_out.w_dst_sel;
    assign R_wb_sel     = c_out.wb_sel;
    assign R_done       = c_out.done;
    assign R_illegal    = c_out.illegal;
    assign R_mem_err    = c_out.mem_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction is expanded into the list of
// per-cycle output vectors the controller must produce (from the instruction
// kind and the memory wait pattern), then played against the DUT.
module tb_multicycle_ctrl;

    localparam int T = 16;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                           OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [3:0] A_AND = 4'h0, A_OR = 4'h1, A_ADD = 4'h2,
                           A_SUB = 4'h6, A_SLT = 4'h7;

    typedef struct packed {
        logic       req, wr, asel, irw, pcw;
        logic [1:0] src;
        logic       a;
        logic [1:0] b;
        logic [3:0] alu;
        logic       wreg, dst, wb, done, ill, err;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] W_op, W_func;
    logic       W_zero, W_mem_ack;
    logic       R_mem_req, R_mem_wr, R_addr_sel, R_ir_wr_ena, R_pc_wr_ena;
    logic [1:0] R_pc_src_sel, R_alu_b_sel;
    logic       R_alu_a_sel;
    logic [3:0] R_alu_sel;
    logic       R_w_reg_ena, R_w_dst_sel, R_wb_sel, R_done, R_illegal, R_mem_err;

    ov_t obs;
    ov_t exp_q[$];
    int  ack_q[$];     // 0 = drive low, 1 = drive high, 2 = don't care (random)
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .W_op(W_op), .W_func(W_func),
        .W_zero(W_zero), .W_mem_ack(W_mem_ack),
        .R_mem_req(R_mem_req), .R_mem_wr(R_mem_wr), .R_addr_sel(R_addr_sel),
        .R_ir_wr_ena(R_ir_wr_ena), .R_pc_wr_ena(R_pc_wr_ena),
        .R_pc_src_sel(R_pc_src_sel), .R_alu_a_sel(R_alu_a_sel),
        .R_alu_b_sel(R_alu_b_sel), .R_alu_sel(R_alu_sel),
        .R_w_reg_ena(R_w_reg_ena), .R_w_dst_sel(R_w_dst_sel),
        .R_wb_sel(R_wb_sel), .R_done(R_done), .R_illegal(R_illegal),
        .R_mem_err(R_mem_err)
    );

    assign obs = {R_mem_req, R_mem_wr, R_addr_sel, R_ir_wr_ena, R_pc_wr_ena,
                  R_pc_src_sel, R_alu_a_sel, R_alu_b_sel, R_alu_sel,
                  R_w_reg_ena, R_w_dst_sel, R_wb_sel, R_done, R_illegal, R_mem_err};

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'h20:   return A_ADD;
            6'h22:   return A_SUB;
            6'h24:   return A_AND;
            6'h25:   return A_OR;
            6'h2A:   return A_SLT;
            default: return A_ADD;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] f);
        return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    task automatic push(input ov_t e, input int a);
        exp_q.push_back(e);
        ack_q.push_back(a);
    endtask

    // A request that waits w cycles: w >= T means it times out.
    // Returns 1 when the request completed with an ack.
    task automatic gen_req(input ov_t e, input int w, output bit acked);
        ov_t t;
        t = e;
        if (w >= T) begin
            for (int i = 0; i < T - 1; i++) push(t, 0);
            t.err = 1'b1;
            push(t, 0);
            acked = 1'b0;
        end else begin
            for (int i = 0; i < w; i++) push(t, 0);
            acked = 1'b1;
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int fw, input int mw);
        ov_t e;
        bit  ok, legal;
        // fetch
        e = '0; e.req = 1; e.b = 2'd1; e.alu = A_ADD;
        gen_req(e, fw, ok);
        if (!ok) return;
        e.irw = 1; e.pcw = 1; e.src = 2'd0;
        push(e, 1);
        // decode
        e = '0; e.b = 2'd3; e.alu = A_ADD;
        legal = (op == OP_R) ? fn_ok(fn) : (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J});
        if (!legal) begin
            e.ill = 1;
            push(e, 2);
            return;
        end
        push(e, 2);
        if (op == OP_R || op == OP_ADDI) begin
            e = '0; e.a = 1;
            e.b   = (op == OP_R) ? 2'd0 : 2'd2;
            e.alu = (op == OP_R) ? alu_of(fn) : A_ADD;
            push(e, 2);
            e = '0; e.wreg = 1; e.dst = (op == OP_R); e.done = 1;
            push(e, 2);
        end else if (op == OP_LW || op == OP_SW) begin
            e = '0; e.a = 1; e.b = 2'd2; e.alu = A_ADD;
            push(e, 2);
            e = '0; e.req = 1; e.asel = 1; e.wr = (op == OP_SW);
            gen_req(e, mw, ok);
            if (!ok) return;
            if (op == OP_SW) begin
                e.done = 1;
                push(e, 1);
            end else begin
                push(e, 1);
                e = '0; e.wreg = 1; e.wb = 1; e.done = 1;
                push(e, 2);
            end
        end else if (op == OP_BEQ) begin
            e = '0; e.a = 1; e.b = 2'd0; e.alu = A_SUB;
            e.pcw = zero; e.src = 2'd1; e.done = 1;
            push(e, 2);
        end else begin
            e = '0; e.pcw = 1; e.src = 2'd2; e.done = 1;
            push(e, 2);
        end
    endtask

    // Play up to maxn queued cycles; reports the cycle index of the first done.
    task automatic run_q(input string tag, input int maxn, output int done_at);
        ov_t e;
        int  a, n;
        n = 0;
        done_at = -1;
        while (exp_q.size() > 0 && n < maxn) begin
            e = exp_q.pop_front();
            a = ack_q.pop_front();
            W_mem_ack = (a == 2) ? 1'($urandom_range(0, 1)) : 1'(a);
            @(negedge clk);
            n++;
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s cyc=%0d obs=%h exp=%h", tag, n, obs, e);
            end
            if (obs.done === 1'b1 && done_at < 0) done_at = n;
            @(posedge clk); #1;
        end
        W_mem_ack = 1'b0;
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, got, want);
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic zero, input int fw, input int mw, output int d);
        W_op = op; W_func = fn; W_zero = zero;
        gen_instr(op, fn, zero, fw, mw);
        run_q(tag, 1000, d);
    endtask

    initial begin
        int  d;
        ov_t fe;
        logic [5:0] ops [7];
        logic [5:0] fns [7];
        ops = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00};

        rst_n = 1'b0; W_op = '0; W_func = '0; W_zero = 1'b0; W_mem_ack = 1'b0;
        // outputs stay low while reset is held, whatever ack does
        for (int i = 0; i < 3; i++) begin
            W_mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            assert (obs === '0) else begin
                bad++;
                $error("FAIL reset obs=%h exp=0", obs);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1; W_mem_ack = 1'b0;

        // directed instructions with latency checks
        instr("add", OP_R, 6'h20, 1'b0, 0, 0, d);       chk_int("add_lat", d, 4);
        instr("lw_wait3", OP_LW, 6'h00, 1'b0, 0, 3, d); chk_int("lw_lat", d, 8);
        instr("beq_z1", OP_BEQ, 6'h00, 1'b1, 0, 0, d);  chk_int("beq1_lat", d, 3);
        instr("beq_z0", OP_BEQ, 6'h00, 1'b0, 0, 0, d);  chk_int("beq0_lat", d, 3);
        instr("ill_op", 6'h3F, 6'h20, 1'b0, 0, 0, d);   chk_int("ill_nodone", d, -1);
        instr("ill_fn", OP_R, 6'h3F, 1'b0, 0, 0, d);
        instr("sw", OP_SW, 6'h00, 1'b0, 0, 0, d);       chk_int("sw_lat", d, 4);
        instr("j", OP_J, 6'h00, 1'b0, 0, 0, d);         chk_int("j_lat", d, 3);
        instr("addi", OP_ADDI, 6'h00, 1'b0, 1, 0, d);   chk_int("addi_lat", d, 5);

        // fetch timeout, then ack on the last allowed cycle
        instr("fetch_to", OP_R, 6'h20, 1'b0, T, 0, d);  chk_int("fetch_to_nodone", d, -1);
        instr("fetch_edge", OP_R, 6'h24, 1'b0, T - 1, 0, d);
        chk_int("fetch_edge_lat", d, T - 1 + 4);
        instr("lw_to", OP_LW, 6'h00, 1'b0, 0, T, d);    chk_int("lw_to_nodone", d, -1);
        instr("sw_edge", OP_SW, 6'h00, 1'b0, 0, T - 1, d);
        chk_int("sw_edge_lat", d, T - 1 + 4);

        // reset pulse in MEM_WR with ack high: nothing is written
        W_op = OP_SW; W_func = '0; W_zero = 1'b0;
        gen_instr(OP_SW, 6'h00, 1'b0, 0, 5);
        run_q("rst_pre", 3, d);
        exp_q.delete(); ack_q.delete();
        rst_n = 1'b0; W_mem_ack = 1'b1;
        @(negedge clk);
        total++;
        assert (obs === '0) else begin
            bad++;
            $error("FAIL rst_memwr obs=%h exp=0", obs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; W_mem_ack = 1'b0;
        fe = '0; fe.req = 1; fe.b = 2'd1; fe.alu = A_ADD;
        @(negedge clk);
        total++;
        assert (obs === fe) else begin
            bad++;
            $error("FAIL rst_resume obs=%h exp=%h", obs, fe);
        end
        @(posedge clk); #1;
        instr("post_rst", OP_R, 6'h2A, 1'b0, 0, 0, d);  chk_int("post_rst_lat", d, 4);

        // randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            int fw, mw, oi;
            logic [5:0] fn;
            oi = $urandom_range(0, 6);
            fn = fns[$urandom_range(0, 6)];
            fw = ($urandom_range(0, 11) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 11) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
            instr("rand", ops[oi], fn, 1'($urandom_range(0, 1)), fw, mw, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
